// File: rtl/quad_pkg.sv
// ============================================================================
//  Module   : quad_pkg
//  Purpose  : Shared definitions for the quadrature step decoder. Holds the
//             Gray-code phase states, the step codes and the transition
//             classifier used by the decode stage.
//  Ports    : n/a (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package quad_pkg;

   // Phase states, written as {A,B}
   localparam logic [1:0] ST00 = 2'b00;
   localparam logic [1:0] ST01 = 2'b01;
   localparam logic [1:0] ST11 = 2'b11;
   localparam logic [1:0] ST10 = 2'b10;

   // Result of comparing two consecutive filtered states
   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_CW   = 2'd1,
      STEP_CCW  = 2'd2,
      STEP_ERR  = 2'd3
   } step_t;

   // Accumulator width: holds -(RES-1)..RES-1 for RES up to 4
   localparam int c_acc_w = 3;

   // Successor of a state along the clockwise sequence 00->01->11->10->00
   function automatic logic [1:0] cw_next(input logic [1:0] st);
      logic [1:0] nxt;
      nxt = ST00;
      case (st)
         ST00:    nxt = ST01;
         ST01:    nxt = ST11;
         ST11:    nxt = ST10;
         default: nxt = ST00;
      endcase
      return nxt;
   endfunction

   // Classify a transition old->new
   function automatic step_t quad_step(input logic [1:0] old_st,
                                       input logic [1:0] new_st);
      step_t s;
      s = STEP_NONE;
      if (old_st == new_st)
         s = STEP_NONE;
      else if ((old_st ^ new_st) == 2'b11)
         s = STEP_ERR;
      else if (new_st == cw_next(old_st))
         s = STEP_CW;
      else
         s = STEP_CCW;
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/quad_step_decoder_if.sv
// ============================================================================
//  Module   : quad_step_decoder_if
//  Purpose  : Encoder-in / counter-control-out signal bundle.
//  Signals  : a_in, b_in  raw encoder phases (asynchronous to clk)
//             ena         one-cycle step strobe
//             dir         step direction, 1 = up/CW, held between strobes
//             err         one-cycle illegal-transition strobe
//  Modports : master - encoder side / observer (drives phases)
//             slave  - decoder side (drives ena/dir/err)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface quad_step_decoder_if;
   logic a_in;
   logic b_in;
   logic ena;
   logic dir;
   logic err;

   modport master (output a_in, output b_in, input ena, input dir, input err);
   modport slave  (input a_in, input b_in, output ena, output dir, output err);
endinterface

`default_nettype wire

// File: rtl/quad_debounce.sv
// ============================================================================
//  Module   : quad_debounce
//  Purpose  : Two-flop synchroniser on both phases followed by a joint
//             debounce counter on the 2-bit {A,B} vector.
//  Ports    : clk       system clock
//             reset     asynchronous active-low reset
//             i_ab      raw {A,B}
//             i_primed  decoder has accepted its first filtered value
//             o_filt    debounced {A,B}
//             o_upd     one-cycle strobe, o_filt has just been loaded
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module quad_debounce
   import quad_pkg::*;
#(
   parameter int DB_LEN = 8,
   parameter int DBW    = 4
) (
   input  wire logic       clk,
   input  wire logic       reset,
   input  wire logic [1:0] i_ab,
   input  wire logic       i_primed,
   output logic      [1:0] o_filt,
   output logic            o_upd
);

   localparam logic [DBW-1:0] c_db_len = DBW'(DB_LEN);
   localparam logic [DBW-1:0] c_one    = DBW'(1);

   logic [1:0]     r_s1;
   logic [1:0]     r_s2;
   logic [1:0]     r_s2_prev;
   logic [1:0]     r_filt;
   logic [DBW-1:0] r_cnt;
   logic           r_upd;

   logic           w_match;
   logic           w_changed;
   logic [DBW-1:0] w_cnt_nxt;
   logic           w_fire;

   // Before priming the counter measures plain stability of s2, so a
   // resting value equal to the reset filt (00) still produces the
   // priming update. After priming it measures time away from filt.
   always_comb begin
      w_match   = i_primed && (r_s2 == r_filt);
      w_changed = (r_s2 != r_s2_prev);
      if (w_match)
         w_cnt_nxt = '0;
      else if (w_changed)
         w_cnt_nxt = c_one;
      else
         w_cnt_nxt = r_cnt + c_one;
      w_fire = !w_match && (w_cnt_nxt == c_db_len);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1      <= ST00;
         r_s2      <= ST00;
         r_s2_prev <= ST00;
         r_filt    <= ST00;
         r_cnt     <= '0;
         r_upd     <= 1'b0;
      end else begin
         r_s1      <= i_ab;
         r_s2      <= r_s1;
         r_s2_prev <= r_s2;
         r_upd     <= w_fire;
         if (w_fire) begin
            r_filt <= r_s2;
            r_cnt  <= '0;
         end else begin
            r_cnt  <= w_cnt_nxt;
         end
      end
   end

   assign o_filt = r_filt;
   assign o_upd  = r_upd;

endmodule

`default_nettype wire

// File: rtl/quad_step_decoder.sv
// ============================================================================
//  Module   : quad_step_decoder
//  Purpose  : Turns a mechanical quadrature encoder into ena/dir controls for
//             an up/down counter: debounce, priming, Gray decode, detent
//             accumulation and registered strobes.
//  Ports    : clk    system clock
//             reset  asynchronous active-low reset
//             bus    quad_step_decoder_if.slave
//                    (a_in, b_in in; ena, dir, err out)
//  Params   : DB_LEN stable clocks before filt updates (1..2^DBW-1)
//             DBW    debounce counter width
//             RES    encoder transitions per emitted step (1, 2, 4)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module quad_step_decoder
   import quad_pkg::*;
#(
   parameter int DB_LEN = 8,
   parameter int DBW    = 4,
   parameter int RES    = 4
) (
   input  wire logic          clk,
   input  wire logic          reset,
   quad_step_decoder_if.slave bus
);

   localparam logic signed [c_acc_w-1:0] c_acc_max = c_acc_w'(RES - 1);
   localparam logic signed [c_acc_w-1:0] c_acc_min = -c_acc_max;
   localparam logic signed [c_acc_w-1:0] c_acc_one = c_acc_w'(1);

   logic [1:0]                w_filt;
   logic                      w_upd;

   logic                      r_primed;
   logic [1:0]                r_last;
   step_t                     r_step;
   logic signed [c_acc_w-1:0] r_acc;
   logic                      r_ena;
   logic                      r_dir;
   logic                      r_err;

   quad_debounce #(
      .DB_LEN (DB_LEN),
      .DBW    (DBW)
   ) u_db (
      .clk      (clk),
      .reset    (reset),
      .i_ab     ({bus.a_in, bus.b_in}),
      .i_primed (r_primed),
      .o_filt   (w_filt),
      .o_upd    (w_upd)
   );

   // Stage 1 classifies the filt transition, stage 2 accumulates and
   // drives the output strobes. The first update after reset only records
   // the resting state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_primed <= 1'b0;
         r_last   <= ST00;
         r_step   <= STEP_NONE;
         r_acc    <= '0;
         r_ena    <= 1'b0;
         r_dir    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_step <= STEP_NONE;
         if (w_upd) begin
            r_last <= w_filt;
            if (!r_primed)
               r_primed <= 1'b1;
            else
               r_step <= quad_step(r_last, w_filt);
         end

         r_ena <= 1'b0;
         r_err <= 1'b0;
         case (r_step)
            STEP_CW: begin
               if (r_acc == c_acc_max) begin
                  r_ena <= 1'b1;
                  r_dir <= 1'b1;
                  r_acc <= '0;
               end else begin
                  r_acc <= r_acc + c_acc_one;
               end
            end
            STEP_CCW: begin
               if (r_acc == c_acc_min) begin
                  r_ena <= 1'b1;
                  r_dir <= 1'b0;
                  r_acc <= '0;
               end else begin
                  r_acc <= r_acc - c_acc_one;
               end
            end
            STEP_ERR: begin
               r_err <= 1'b1;
               r_acc <= '0;
            end
            default: ;
         endcase
      end
   end

   assign bus.ena = r_ena;
   assign bus.dir = r_dir;
   assign bus.err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
// ============================================================================
//  Module   : tb_quad_step_decoder
//  Purpose  : Directed bench for quad_step_decoder. Two instances share the
//             clock: dut4 (RES=4) and dut1 (RES=1), both DB_LEN=8.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_quad_step_decoder;

   typedef struct {
      logic [1:0] ab;     // {a_in,b_in} applied
      int         hold;   // clocks held
      int         n_ena;  // ena pulses expected in the window
      int         n_err;  // err pulses expected in the window
      logic       dir;    // dir expected at end of window
      int         lat;    // tick of first ena/err pulse, 0 = not checked
   } vec_t;

   logic clk = 1'b0;
   logic rst4_n;
   logic rst1_n;
   always #5 clk = ~clk;

   quad_step_decoder_if if4 ();
   quad_step_decoder_if if1 ();

   quad_step_decoder #(.DB_LEN(8), .DBW(4), .RES(4)) dut4 (
      .clk   (clk),
      .reset (rst4_n),
      .bus   (if4.slave)
   );

   quad_step_decoder #(.DB_LEN(8), .DBW(4), .RES(1)) dut1 (
      .clk   (clk),
      .reset (rst1_n),
      .bus   (if1.slave)
   );

   int   n_vec = 0;
   int   n_bad = 0;
   logic prev_ena4 = 1'b0;
   logic prev_ena1 = 1'b0;

   vec_t tab4 [16];
   vec_t tab1 [4];

   task automatic chk(input string name, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
      end
   endtask

   task automatic drive(input int sel, input logic [1:0] ab);
      if (sel == 0) begin
         if4.a_in = ab[1];
         if4.b_in = ab[0];
      end else begin
         if1.a_in = ab[1];
         if1.b_in = ab[0];
      end
   endtask

   // One clock; outputs sampled 1 time unit after the rising edge.
   task automatic tick(input int sel, output logic e, output logic r);
      logic p;
      @(posedge clk);
      #1;
      if (sel == 0) begin
         e = if4.ena; r = if4.err; p = prev_ena4; prev_ena4 = e;
      end else begin
         e = if1.ena; r = if1.err; p = prev_ena1; prev_ena1 = e;
      end
      if (e && r) begin
         n_bad++;
         $display("FAIL ena_err_overlap dut%0d: ena=1 err=1, required not both", sel);
      end
      if (e && p) begin
         n_bad++;
         $display("FAIL ena_back_to_back dut%0d: ena high two cycles, required single", sel);
      end
   endtask

   task automatic run(input int sel, input int n, output int ne, output int nr);
      logic e, r;
      ne = 0;
      nr = 0;
      for (int t = 0; t < n; t++) begin
         tick(sel, e, r);
         if (e) ne++;
         if (r) nr++;
      end
   endtask

   task automatic apply(input int sel, input vec_t v, input string tag);
      int   ne, nr, first;
      logic e, r, d;
      ne = 0; nr = 0; first = 0;
      drive(sel, v.ab);
      for (int t = 1; t <= v.hold; t++) begin
         tick(sel, e, r);
         if (e) ne++;
         if (r) nr++;
         if ((e || r) && first == 0) first = t;
      end
      d = (sel == 0) ? if4.dir : if1.dir;
      chk({tag, "_ena_cnt"}, ne, v.n_ena);
      chk({tag, "_err_cnt"}, nr, v.n_err);
      chk({tag, "_dir"}, int'(d), int'(v.dir));
      if (v.lat != 0) chk({tag, "_latency"}, first, v.lat);
   endtask

   initial begin
      int   ne, nr;
      logic e, r;

      // RES=4: CW detent, CCW detent, cancelling jitter, illegal jump
      // (after one CW step so a missing clear would show), then 4 fresh CW.
      tab4[0]  = '{2'b01, 16, 0, 0, 1'b0, 0};
      tab4[1]  = '{2'b11, 16, 0, 0, 1'b0, 0};
      tab4[2]  = '{2'b10, 16, 0, 0, 1'b0, 0};
      tab4[3]  = '{2'b00, 16, 1, 0, 1'b1, 12};
      tab4[4]  = '{2'b10, 16, 0, 0, 1'b1, 0};
      tab4[5]  = '{2'b11, 16, 0, 0, 1'b1, 0};
      tab4[6]  = '{2'b01, 16, 0, 0, 1'b1, 0};
      tab4[7]  = '{2'b00, 16, 1, 0, 1'b0, 12};
      tab4[8]  = '{2'b01, 16, 0, 0, 1'b0, 0};
      tab4[9]  = '{2'b00, 16, 0, 0, 1'b0, 0};
      tab4[10] = '{2'b01, 16, 0, 0, 1'b0, 0};
      tab4[11] = '{2'b10, 16, 0, 1, 1'b0, 12};
      tab4[12] = '{2'b00, 16, 0, 0, 1'b0, 0};
      tab4[13] = '{2'b01, 16, 0, 0, 1'b0, 0};
      tab4[14] = '{2'b11, 16, 0, 0, 1'b0, 0};
      tab4[15] = '{2'b10, 16, 1, 0, 1'b1, 12};

      // RES=1: every transition is a detent
      tab1[0]  = '{2'b01, 16, 1, 0, 1'b1, 12};
      tab1[1]  = '{2'b11, 16, 1, 0, 1'b1, 12};
      tab1[2]  = '{2'b10, 16, 1, 0, 1'b1, 12};
      tab1[3]  = '{2'b00, 16, 1, 0, 1'b1, 12};

      rst4_n = 1'b0;
      rst1_n = 1'b0;
      drive(0, 2'b11);
      drive(1, 2'b00);
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("rst_ena", int'(if4.ena), 0);
      chk("rst_dir", int'(if4.dir), 0);
      chk("rst_err", int'(if4.err), 0);
      chk("rst_filt", int'(dut4.u_db.r_filt), 0);
      chk("rst_primed", int'(dut4.r_primed), 0);

      // Resting at 11 out of reset: primes silently
      rst4_n = 1'b1;
      run(0, 20, ne, nr);
      chk("prime11_ena_cnt", ne, 0);
      chk("prime11_err_cnt", nr, 0);
      chk("prime11_filt", int'(dut4.u_db.r_filt), 3);
      chk("prime11_primed", int'(dut4.r_primed), 1);

      // Re-prime resting at 00
      rst4_n = 1'b0;
      drive(0, 2'b00);
      run(0, 2, ne, nr);
      rst4_n = 1'b1;
      run(0, 20, ne, nr);
      chk("prime00_ena_cnt", ne, 0);
      chk("prime00_primed", int'(dut4.r_primed), 1);

      for (int i = 0; i < 12; i++) apply(0, tab4[i], $sformatf("r4v%0d", i));
      chk("illegal_acc_clear", int'(dut4.r_acc), 0);
      for (int i = 12; i < 16; i++) apply(0, tab4[i], $sformatf("r4v%0d", i));

      // Glitch on b_in shorter than DB_LEN (filt is 10 here)
      drive(0, 2'b11);
      run(0, 5, ne, nr);
      drive(0, 2'b10);
      begin
         int ne2, nr2;
         run(0, 16, ne2, nr2);
         chk("glitch_ena_cnt", ne + ne2, 0);
         chk("glitch_err_cnt", nr + nr2, 0);
      end
      chk("glitch_filt", int'(dut4.u_db.r_filt), 2);

      // RES=1 instance, primed at 00
      rst1_n = 1'b1;
      run(1, 20, ne, nr);
      chk("r1_prime_ena_cnt", ne, 0);
      for (int i = 0; i < 4; i++) apply(1, tab1[i], $sformatf("r1v%0d", i));

      // Reset asserted while an ena pulse is on the output
      drive(1, 2'b01);
      run(1, 11, ne, nr);
      tick(1, e, r);
      chk("r1_pre_reset_ena", int'(e), 1);
      rst1_n = 1'b0;
      #1;
      chk("async_rst_ena", int'(if1.ena), 0);
      chk("async_rst_dir", int'(if1.dir), 0);
      chk("async_rst_primed", int'(dut1.r_primed), 0);
      run(1, 2, ne, nr);
      rst1_n = 1'b1;
      run(1, 20, ne, nr);
      chk("r1_reprime_ena_cnt", ne, 0);
      chk("r1_reprime_err_cnt", nr, 0);
      chk("r1_reprime_filt", int'(dut1.u_db.r_filt), 1);
      apply(1, '{2'b00, 16, 1, 0, 1'b0, 12}, "r1_post_ccw");
      apply(1, '{2'b01, 16, 1, 0, 1'b1, 12}, "r1_post_cw");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
